spi_slave: RTL

- SPI responder (target) for the byte-oriented SPI master driver, SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- Oversamples external sck/cs/mosi in the system clock domain, deserialises received bytes and serialises transmit bytes on miso.
- Used for loopback verification of the flash/SPI path and as an FPGA-side register-access target.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_slave_if.sv | 65 ++++++
 rtl/spi_pin_sync.sv | 44 ++++
 rtl/spi_slave.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI responder slice.
//   state_t        : FSM encoding of the responder (IDLE / LOAD / SHIFT).
//   SPI_MODE0      : {cpol, cpha} of the only supported SPI mode.
//   DEFAULT_DATA_W : default word width in bits.
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [1:0] SPI_MODE0      = 2'b00;
    localparam int         DEFAULT_DATA_W = 8;

endpackage

// File: rtl/spi_slave_if.sv
// ---------------------------------------------------------------------------
// spi_slave_if
// Bundles the SPI pins and the word-side transmit/receive signals of the
// responder.
//   sck, cs, mosi, miso : SPI pins (cs active low, mode 0, MSB first).
//   miso_oe             : tri-state enable, only with SPI_SLAVE_MISO_OE_EN.
//   tx_data/tx_valid/tx_ready : transmit word handshake.
//   rx_data/rx_valid    : received word and its one-cycle update strobe.
//   tx_underrun, frame_abort : one-cycle event strobes.
//   busy                : synchronised cs is low.
//   dbg_state           : current responder FSM state.
//
// Handshake: a word is transferred on every clk edge where tx_valid and
// tx_ready are both high. tx_ready does not depend on tx_valid. The producer
// keeps tx_data stable while tx_valid is high and ready is low. rx_valid has
// no ready: the consumer must take rx_data in the pulse cycle or lose it.
// ---------------------------------------------------------------------------
interface spi_slave_if
    import spi_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) ();

    logic              sck;
    logic              cs;
    logic              mosi;
    logic              miso;
`ifdef SPI_SLAVE_MISO_OE_EN
    logic              miso_oe;
`endif
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              frame_abort;
    logic              busy;
    state_t            dbg_state;

`ifdef SPI_SLAVE_MISO_OE_EN
    modport slave (
        input  sck, cs, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid,
               tx_underrun, frame_abort, busy, dbg_state
    );
    modport master (
        output sck, cs, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid,
               tx_underrun, frame_abort, busy, dbg_state
    );
`else
    modport slave (
        input  sck, cs, mosi, tx_data, tx_valid,
        output miso, tx_ready, rx_data, rx_valid,
               tx_underrun, frame_abort, busy, dbg_state
    );
    modport master (
        output sck, cs, mosi, tx_data, tx_valid,
        input  miso, tx_ready, rx_data, rx_valid,
               tx_underrun, frame_abort, busy, dbg_state
    );
`endif

endinterface

// File: rtl/spi_pin_sync.sv
// ---------------------------------------------------------------------------
// spi_pin_sync
// Brings one asynchronous pin into the clk domain through SYNC_STAGES
// flip-flops (minimum 2) followed by one history register for edge detection.
//   clk, rst : system clock, synchronous active-high reset.
//   i_pin    : asynchronous input pin.
//   o_level  : synchronised level.
//   o_rise   : one-cycle strobe on a rising edge of o_level.
//   o_fall   : one-cycle strobe on a falling edge of o_level.
// RESET_VAL is the idle level of the pin, so leaving reset with the pin idle
// produces no spurious edge.
// ---------------------------------------------------------------------------
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Strobes are formed from registers only; the FSM acts on them at the
    // following edge, SYNC_STAGES+1 clk after the pin moved.
    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// SPI mode-0, MSB-first responder. sck/cs/mosi are oversampled in the clk
// domain (sck at most clk/8), received bits are assembled into words and a
// single-entry holding register feeds the transmit shifter.
//   clk, rst : system clock, synchronous active-high reset.
//   bus      : spi_slave_if.slave (pins, tx handshake, rx word, events,
//              busy, dbg_state).
// Optional build macro SPI_SLAVE_MISO_OE_EN adds bus.miso_oe (high while
// busy) and forces miso low whenever miso_oe is low.
// ---------------------------------------------------------------------------
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_slave_if.slave   bus
);

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic w_sck_rise, w_sck_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_mosi_level;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .i_pin(bus.sck),
        .o_level(), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .i_pin(bus.cs),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .i_pin(bus.mosi),
        .o_level(w_mosi_level), .o_rise(), .o_fall()
    );

    state_t            r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_tx_shreg;
    logic [DATA_W-2:0] r_rx_shreg;
    logic [DATA_W-1:0] r_hold;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_tx_underrun;
    logic              r_frame_abort;
    logic              r_busy;

    logic              w_write;
    logic              w_take;
    logic [DATA_W-1:0] w_rx_word;

    assign w_write   = bus.tx_valid & ~r_hold_full;
    assign w_take    = (r_state == LOAD) & ~w_cs_rise & r_hold_full;
    assign w_rx_word = {r_rx_shreg, w_mosi_level};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_tx_shreg    <= '0;
            r_rx_shreg    <= '0;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_abort <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_abort <= 1'b0;
            r_busy        <= ~w_cs_level;

            // Holding register: a write can only happen while empty, so a
            // write in a LOAD cycle means LOAD saw it empty and the new word
            // is simply kept for the next LOAD.
            if (w_write) begin
                r_hold      <= bus.tx_data;
                r_hold_full <= 1'b1;
            end else if (w_take) begin
                r_hold_full <= 1'b0;
            end

            if (w_cs_rise) begin
                // End of frame from any state; a non-zero count means a
                // partial word, which is dropped.
                r_state    <= IDLE;
                r_bit_cnt  <= '0;
                r_tx_shreg <= '0;
                r_rx_shreg <= '0;
                if (r_bit_cnt != '0) begin
                    r_frame_abort <= 1'b1;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_cs_fall) begin
                            r_state <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (r_hold_full) begin
                            r_tx_shreg <= r_hold;
                        end else begin
                            r_tx_shreg    <= '0;
                            r_tx_underrun <= 1'b1;
                        end
                        r_state <= SHIFT;
                    end
                    SHIFT: begin
                        if (w_sck_rise) begin
                            r_rx_shreg <= w_rx_word[DATA_W-2:0];
                            if (r_bit_cnt == LAST_BIT) begin
                                r_rx_data  <= w_rx_word;
                                r_rx_valid <= 1'b1;
                                r_bit_cnt  <= '0;
                                r_state    <= LOAD;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else if (w_sck_fall && (r_bit_cnt != '0)) begin
                            // With a zero count the fall is either the one
                            // closing the previous word or absent; skipping
                            // it keeps the freshly loaded MSB on miso.
                            r_tx_shreg <= {r_tx_shreg[DATA_W-2:0], 1'b0};
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef SPI_SLAVE_MISO_OE_EN
    assign bus.miso    = r_tx_shreg[DATA_W-1] & r_busy;
    assign bus.miso_oe = r_busy;
`else
    assign bus.miso    = r_tx_shreg[DATA_W-1];
`endif
    assign bus.tx_ready    = ~r_hold_full;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.tx_underrun = r_tx_underrun;
    assign bus.frame_abort = r_frame_abort;
    assign bus.busy        = r_busy;
    assign bus.dbg_state   = r_state;

endmodule
